vc_out_scheduler: RTL and testbench
===================================

VC_OUT_SCHEDULER -- requirements
Module: vc_out_scheduler

Interface
REQ-001 Parameter NUM_IN, default 4, SHALL set the number of input modules competing for the output port.
REQ-002 Parameter NUM_VC, default 2, SHALL set the number of virtual channels and SHALL be at least 2.
REQ-003 Parameter CRED_DEPTH, default 4, SHALL set the downstream buffer depth per VC; CW = $clog2(CRED_DEPTH+1).
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 arst  in  1  SHALL be the reset, synchronous and active-high.
REQ-006 req_i  in  NUM_VC*NUM_IN  SHALL carry the valid flit request from input i on VC v at bit v*NUM_IN+i.
REQ-007 head_i  in  NUM_IN  SHALL mark input i's current flit as a head flit.
REQ-008 tail_i  in  NUM_IN  SHALL mark input i's current flit as the last flit of its packet; head_i and tail_i both high means a single-flit packet.
REQ-009 out_ready_i  in  1  SHALL mean the output link accepts a flit this cycle.
REQ-010 cred_ret_i  in  NUM_VC  SHALL return one downstream credit to VC v when bit v is high.
REQ-011 grant_o  out  NUM_VC*NUM_IN  SHALL be one-hot or zero, marking the input and VC driving the output this cycle.
REQ-012 vc_sel_o  out  $clog2(NUM_VC)  SHALL give the selected VC; 0 when grant_o is zero.
REQ-013 fire_o  out  1  SHALL be high when a flit transfers: |grant_o and out_ready_i.
REQ-014 lock_o  out  NUM_VC  SHALL show which VCs are in LOCKED state.
REQ-015 credit_o  out  NUM_VC*CW  SHALL expose each VC's current credit count.
REQ-016 err_o  out  1  SHALL be a sticky credit-overflow flag.

Function
REQ-017 Each VC SHALL hold a two-state FSM (IDLE, LOCKED), an owner index, and a round-robin pointer.
REQ-018 In IDLE, the VC candidate SHALL be the first input, searching upward from the pointer and wrapping, with req_i and head_i both high; requests without head_i SHALL be ignored.
REQ-019 In LOCKED, the candidate SHALL be the owner only, and only when the owner's req_i bit for that VC is high; other inputs SHALL NOT be granted.
REQ-020 A VC SHALL be eligible when it has a candidate and its credit is nonzero.
REQ-021 Among eligible VCs, the highest VC index SHALL win; grant_o and vc_sel_o SHALL be combinational in the same cycle, with zero latency.
REQ-022 On fire_o with head and not tail: IDLE->LOCKED, owner := granted input.
REQ-023 On fire_o with tail: LOCKED->IDLE, or stay IDLE for a single-flit packet, and the pointer := granted input+1 modulo NUM_IN.
REQ-024 On fire_o with neither head nor tail, the state SHALL be unchanged.
REQ-025 Without fire_o, the FSM, owner and pointer SHALL hold; a locked VC whose owner stalls SHALL stay LOCKED, with no preemption.
REQ-026 On fire_o, credit of vc_sel_o SHALL decrement by 1; on cred_ret_i[v], credit[v] SHALL increment by 1.
REQ-027 A fire and a return on the same VC in the same cycle SHALL leave the credit unchanged.
REQ-028 A return to a VC at CRED_DEPTH, with no same-VC fire, SHALL keep CRED_DEPTH and set err_o until reset.
REQ-029 Credit SHALL never go below 0, because a VC with 0 credit is never granted.
REQ-030 An ineligible higher VC SHALL NOT block a lower eligible VC.

Reset
REQ-031 Asserting arst at a clock edge SHALL set all VCs IDLE, owners 0, pointers 0, credits CRED_DEPTH, and err_o 0.
REQ-032 During reset, grant_o, vc_sel_o, fire_o and lock_o SHALL be 0, and credit_o SHALL show CRED_DEPTH.
REQ-033 Reset mid-packet SHALL abandon the lock and restore full credits with no residual grant.

Verification
REQ-034 Reset, then req_i on VC0 inputs 1 and 3 with head=tail=1 and out_ready_i=1 for 2 cycles -> grant input1 then input3; credit_o VC0 4->3->2.
REQ-035 Input0 sends 3-flit packet on VC1 (H,B,T) while input2 requests VC1 head -> input0 granted 3 consecutive cycles; lock_o[1]=1 after head and 0 after tail; input2 granted on the 4th cycle.
REQ-036 VC1 and VC0 both eligible -> VC1 selected; drain VC1 credit to 0 -> VC0 granted next cycle; vc_sel_o=0.
REQ-037 out_ready_i=0 with a valid grant for 3 cycles -> grant_o stable, fire_o=0, credits unchanged.
REQ-038 Credit at 2 with fire and cred_ret_i on the same VC -> stays 2; cred_ret_i at 4 -> stays 4 and err_o=1 thereafter.
REQ-039 arst asserted while VC0 is LOCKED by input2 -> next cycle lock_o=0, credits=4, and input1 head granted on VC0.

Source files
------------

// File: rtl/vc_out_scheduler.sv
// Output-port scheduler: per-VC wormhole lock with round-robin head arbitration,
// fixed highest-VC priority across VCs, and per-VC downstream credit tracking.
module vc_out_scheduler #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned CRED_DEPTH = 4,
    localparam int unsigned CW        = $clog2(CRED_DEPTH + 1),
    localparam int unsigned VW        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int unsigned IW        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [NUM_VC*NUM_IN-1:0] req_i,
    input  logic [NUM_IN-1:0]        head_i,
    input  logic [NUM_IN-1:0]        tail_i,
    input  logic                     out_ready_i,
    input  logic [NUM_VC-1:0]        cred_ret_i,
    output logic [NUM_VC*NUM_IN-1:0] grant_o,
    output logic [VW-1:0]            vc_sel_o,
    output logic                     fire_o,
    output logic [NUM_VC-1:0]        lock_o,
    output logic [NUM_VC*CW-1:0]     credit_o,
    output logic                     err_o
);

    if (NUM_VC < 2) begin : g_bad_num_vc
        $error("vc_out_scheduler: NUM_VC must be at least 2");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } vc_state_e;

    vc_state_e         state_q  [NUM_VC];
    vc_state_e         state_d  [NUM_VC];
    logic [IW-1:0]     owner_q  [NUM_VC];
    logic [IW-1:0]     owner_d  [NUM_VC];
    logic [IW-1:0]     ptr_q    [NUM_VC];
    logic [IW-1:0]     ptr_d    [NUM_VC];
    logic [CW-1:0]     credit_q [NUM_VC];
    logic [CW-1:0]     credit_d [NUM_VC];
    logic              err_q;
    logic              err_d;

    logic              has_cand [NUM_VC];
    logic [IW-1:0]     cand_in  [NUM_VC];
    logic [NUM_VC-1:0] elig;
    logic              any_win;
    logic [VW-1:0]     win_vc;
    logic [IW-1:0]     win_in;
    logic              fire;

    // Per-VC candidate: owner while locked, else first head request from the pointer
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int v = 0; v < NUM_VC; v++) begin
            has_cand[v] = 1'b0;
            cand_in[v]  = '0;
            if (state_q[v] == LOCKED) begin
                if (req_i[32'(v) * NUM_IN + 32'(owner_q[v])]) begin
                    has_cand[v] = 1'b1;
                    cand_in[v]  = owner_q[v];
                end
            end else begin
                for (int k = 0; k < NUM_IN; k++) begin
                    idx = (32'(ptr_q[v]) + 32'(k)) % NUM_IN;
                    if (!has_cand[v] && req_i[32'(v) * NUM_IN + idx] && head_i[idx]) begin
                        has_cand[v] = 1'b1;
                        cand_in[v]  = IW'(idx);
                    end
                end
            end
            elig[v] = has_cand[v] && (credit_q[v] != '0);
        end
    end

    // Highest eligible VC wins; later iterations override lower VCs
    always_comb begin
        any_win = 1'b0;
        win_vc  = '0;
        win_in  = '0;
        if (!arst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (elig[v]) begin
                    any_win = 1'b1;
                    win_vc  = VW'(v);
                    win_in  = cand_in[v];
                end
            end
        end
    end

    assign fire = any_win && out_ready_i;

    always_comb begin
        grant_o = '0;
        if (any_win) begin
            grant_o[32'(win_vc) * NUM_IN + 32'(win_in)] = 1'b1;
        end
    end

    assign vc_sel_o = win_vc;
    assign fire_o   = fire;
    assign err_o    = err_q && !arst;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            lock_o[v]                = (state_q[v] == LOCKED) && !arst;
            credit_o[v*CW +: CW]     = arst ? CW'(CRED_DEPTH) : credit_q[v];
        end
    end

    // Next-state: lock FSM, owner, pointer and credit per VC
    always_comb begin
        logic sel_fire;
        logic win_head;
        logic win_tail;
        sel_fire = 1'b0;
        win_head = head_i[win_in];
        win_tail = tail_i[win_in];
        err_d    = err_q;
        for (int v = 0; v < NUM_VC; v++) begin
            state_d[v]  = state_q[v];
            owner_d[v]  = owner_q[v];
            ptr_d[v]    = ptr_q[v];
            credit_d[v] = credit_q[v];

            sel_fire = fire && (win_vc == VW'(v));

            case (state_q[v])
                IDLE: begin
                    if (sel_fire && win_head && !win_tail) begin
                        state_d[v] = LOCKED;
                        owner_d[v] = win_in;
                    end
                end
                LOCKED: begin
                    if (sel_fire && win_tail) begin
                        state_d[v] = IDLE;
                    end else if (sel_fire && win_head) begin
                        owner_d[v] = win_in;
                    end
                end
                default: state_d[v] = IDLE;
            endcase

            if (sel_fire && win_tail) begin
                ptr_d[v] = (win_in == IW'(NUM_IN - 1)) ? '0 : win_in + IW'(1);
            end

            // Fire and return on the same VC cancel; a return at full depth is an overflow
            if (sel_fire && !cred_ret_i[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (!sel_fire && cred_ret_i[v]) begin
                if (credit_q[v] == CW'(CRED_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v]  <= IDLE;
                owner_q[v]  <= '0;
                ptr_q[v]    <= '0;
                credit_q[v] <= CW'(CRED_DEPTH);
            end
            err_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v]  <= state_d[v];
                owner_q[v]  <= owner_d[v];
                ptr_q[v]    <= ptr_d[v];
                credit_q[v] <= credit_d[v];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_vc_out_scheduler.sv
// Directed bench for vc_out_scheduler: per-cycle comparison against a
// packet-level model plus literal expectations for the key scenarios.
module tb_vc_out_scheduler;

    localparam int N  = 4;
    localparam int V  = 2;
    localparam int D  = 4;
    localparam int CW = 3;

    logic             clk;
    logic             arst;
    logic [V*N-1:0]   req;
    logic [N-1:0]     head;
    logic [N-1:0]     tail;
    logic             out_ready;
    logic [V-1:0]     cred_ret;
    logic [V*N-1:0]   grant;
    logic             vc_sel;
    logic             fire;
    logic [V-1:0]     lock;
    logic [V*CW-1:0]  credit;
    logic             err;

    int checks   = 0;
    int failures = 0;

    // Model state: packet-level view of each VC
    bit m_lock  [V];
    int m_owner [V];
    int m_ptr   [V];
    int m_cred  [V];
    bit m_err;

    vc_out_scheduler #(.NUM_IN(N), .NUM_VC(V), .CRED_DEPTH(D)) dut (
        .clk         (clk),
        .arst        (arst),
        .req_i       (req),
        .head_i      (head),
        .tail_i      (tail),
        .out_ready_i (out_ready),
        .cred_ret_i  (cred_ret),
        .grant_o     (grant),
        .vc_sel_o    (vc_sel),
        .fire_o      (fire),
        .lock_o      (lock),
        .credit_o    (credit),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Which packet owns the link this cycle, judged from the model's view
    function automatic void mdl_pick(output bit found, output int wv, output int wi);
        found = 0;
        wv    = 0;
        wi    = 0;
        for (int v = V - 1; v >= 0; v--) begin
            bit has;
            int c;
            has = 0;
            c   = 0;
            if (m_lock[v]) begin
                if (req[v*N + m_owner[v]]) begin
                    has = 1;
                    c   = m_owner[v];
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr[v] + k) % N;
                    if (!has && req[v*N + i] && head[i]) begin
                        has = 1;
                        c   = i;
                    end
                end
            end
            if (!found && has && m_cred[v] > 0) begin
                found = 1;
                wv    = v;
                wi    = c;
            end
        end
    endfunction

    always @(posedge clk) begin
        bit found;
        int wv;
        int wi;
        if (arst) begin
            for (int v = 0; v < V; v++) begin
                m_lock[v]  = 0;
                m_owner[v] = 0;
                m_ptr[v]   = 0;
                m_cred[v]  = D;
            end
            m_err = 0;
        end else begin
            mdl_pick(found, wv, wi);
            for (int v = 0; v < V; v++) begin
                int delta;
                delta = 0;
                if (found && out_ready && wv == v) delta = delta - 1;
                if (cred_ret[v]) delta = delta + 1;
                if (m_cred[v] + delta > D) m_err = 1;
                else m_cred[v] = m_cred[v] + delta;
            end
            if (found && out_ready) begin
                if (tail[wi]) begin
                    m_lock[wv] = 0;
                    m_ptr[wv]  = (wi + 1) % N;
                end else if (head[wi]) begin
                    m_lock[wv]  = 1;
                    m_owner[wv] = wi;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        bit found;
        int wv;
        int wi;
        logic [V*N-1:0]  e_grant;
        logic [V-1:0]    e_lock;
        logic [V*CW-1:0] e_cred;
        e_grant = '0;
        e_lock  = '0;
        e_cred  = '0;
        found   = 0;
        wv      = 0;
        wi      = 0;
        if (arst) begin
            for (int v = 0; v < V; v++) e_cred[v*CW +: CW] = CW'(D);
        end else begin
            mdl_pick(found, wv, wi);
            if (found) e_grant[wv*N + wi] = 1'b1;
            for (int v = 0; v < V; v++) begin
                e_lock[v]          = m_lock[v];
                e_cred[v*CW +: CW] = CW'(m_cred[v]);
            end
        end
        chk("mdl_grant",  32'(grant),  32'(e_grant));
        chk("mdl_vc_sel", 32'(vc_sel), 32'(wv));
        chk("mdl_fire",   32'(fire),   32'(found && out_ready));
        chk("mdl_lock",   32'(lock),   32'(e_lock));
        chk("mdl_credit", 32'(credit), 32'(e_cred));
        chk("mdl_err",    32'(err),    32'(arst ? 1'b0 : m_err));
    end

    task automatic set_in(input logic [V*N-1:0] r, input logic [N-1:0] h, input logic [N-1:0] t,
                          input logic rdy, input logic [V-1:0] cr);
        req       = r;
        head      = h;
        tail      = t;
        out_ready = rdy;
        cred_ret  = cr;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        set_in('0, '0, '0, 1'b0, '0);
        at_neg();
        chk("rst_credit", 32'(credit), 32'd36);
        chk("rst_lock",   32'(lock),   32'd0);
        chk("rst_grant",  32'(grant),  32'd0);
        tick();
        arst = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        set_in('0, '0, '0, 1'b0, '0);
        tick();
        tick();

        // Round-robin single-flit packets on VC0
        do_reset();
        set_in(8'h0A, 4'hA, 4'hA, 1'b1, 2'b00);
        at_neg();
        chk("rr_first_grant", 32'(grant), 32'h02);
        chk("rr_first_credit", 32'(credit), 32'd36);
        tick();
        at_neg();
        chk("rr_second_grant", 32'(grant), 32'h08);
        chk("rr_second_credit", 32'(credit), 32'd35);
        tick();
        set_in('0, '0, '0, 1'b0, '0);
        at_neg();
        chk("rr_final_credit", 32'(credit), 32'd34);
        tick();

        // Wormhole lock on VC1 holds off a competing head
        do_reset();
        set_in(8'h50, 4'h5, 4'h0, 1'b1, 2'b00);
        at_neg();
        chk("wh_head_grant", 32'(grant), 32'h10);
        chk("wh_head_vcsel", 32'(vc_sel), 32'd1);
        tick();
        set_in(8'h50, 4'h4, 4'h0, 1'b1, 2'b00);
        at_neg();
        chk("wh_body_grant", 32'(grant), 32'h10);
        chk("wh_body_lock", 32'(lock), 32'd2);
        tick();
        set_in(8'h50, 4'h4, 4'h1, 1'b1, 2'b00);
        at_neg();
        chk("wh_tail_grant", 32'(grant), 32'h10);
        tick();
        set_in(8'h40, 4'h4, 4'h4, 1'b1, 2'b00);
        at_neg();
        chk("wh_next_grant", 32'(grant), 32'h40);
        chk("wh_unlock", 32'(lock), 32'd0);
        chk("wh_credit", 32'(credit), 32'd12);
        tick();
        set_in('0, '0, '0, 1'b0, '0);
        at_neg();
        chk("wh_credit_zero", 32'(credit), 32'd4);
        tick();

        // VC priority and fallback when VC1 runs out of credit, then stall
        do_reset();
        set_in(8'h21, 4'h3, 4'h3, 1'b1, 2'b00);
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("pri_vc1_grant", 32'(grant), 32'h20);
            chk("pri_vc1_sel", 32'(vc_sel), 32'd1);
            tick();
        end
        at_neg();
        chk("pri_vc0_grant", 32'(grant), 32'h01);
        chk("pri_vc0_sel", 32'(vc_sel), 32'd0);
        chk("pri_credit", 32'(credit), 32'd4);
        tick();
        set_in(8'h21, 4'h3, 4'h3, 1'b0, 2'b00);
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk("stall_grant", 32'(grant), 32'h01);
            chk("stall_fire", 32'(fire), 32'd0);
            chk("stall_credit", 32'(credit), 32'd3);
            tick();
        end

        // Credit arithmetic and sticky overflow
        do_reset();
        set_in(8'h01, 4'h1, 4'h1, 1'b1, 2'b00);
        tick();
        tick();
        set_in(8'h01, 4'h1, 4'h1, 1'b1, 2'b01);
        at_neg();
        chk("cr_same_fire", 32'(fire), 32'd1);
        chk("cr_before", 32'(credit), 32'd34);
        tick();
        set_in('0, '0, '0, 1'b0, 2'b01);
        at_neg();
        chk("cr_cancel", 32'(credit), 32'd34);
        tick();
        at_neg();
        chk("cr_ret_one", 32'(credit), 32'd35);
        tick();
        at_neg();
        chk("cr_full", 32'(credit), 32'd36);
        chk("cr_err_clear", 32'(err), 32'd0);
        tick();
        at_neg();
        chk("cr_overflow_hold", 32'(credit), 32'd36);
        chk("cr_err_set", 32'(err), 32'd1);
        set_in('0, '0, '0, 1'b0, '0);
        tick();
        at_neg();
        chk("cr_err_sticky", 32'(err), 32'd1);
        tick();

        // Reset in the middle of a locked packet
        do_reset();
        set_in(8'h04, 4'h4, 4'h0, 1'b1, 2'b00);
        at_neg();
        chk("mr_head_grant", 32'(grant), 32'h04);
        tick();
        set_in(8'h04, 4'h0, 4'h0, 1'b0, 2'b00);
        at_neg();
        chk("mr_locked", 32'(lock), 32'd1);
        chk("mr_owner_grant", 32'(grant), 32'h04);
        tick();
        arst = 1'b1;
        set_in(8'h06, 4'h2, 4'h2, 1'b1, 2'b00);
        at_neg();
        chk("mr_rst_grant", 32'(grant), 32'd0);
        chk("mr_rst_fire", 32'(fire), 32'd0);
        chk("mr_rst_credit", 32'(credit), 32'd36);
        tick();
        arst = 1'b0;
        at_neg();
        chk("mr_after_grant", 32'(grant), 32'h02);
        chk("mr_after_lock", 32'(lock), 32'd0);
        chk("mr_after_credit", 32'(credit), 32'd36);
        tick();
        set_in('0, '0, '0, 1'b0, '0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
